// File: rtl/clkgen_ce_multi.sv
// -----------------------------------------------------------------------------
// clkgen_ce_multi
//
// Multi-channel, runtime-programmable fractional clock-enable generator.
// Each channel is a phase accumulator clocked by refclk. The carry out of the
// accumulator is a single-cycle clock enable. The accumulator MSB is a
// 50%-duty square output. Channel rate = f_refclk * inc / 2^ACC_W.
//
// New increments are written into per-channel shadow registers. They only
// become active when cfg_apply copies every shadow into the active set at
// once. The apply also clears all accumulators so that every channel starts
// phase-aligned. A small lock FSM holds `locked` low for LOCK_CYCLES edges
// after reset or after any apply.
//
// Parameters:
//   CHANNELS    number of output channels (1..16)
//   ACC_W       accumulator / increment width (4..48)
//   LOCK_CYCLES settle time in refclk edges before locked asserts (>=1)
//   INIT_INC    packed reset increments, channel i in [i*ACC_W +: ACC_W]
//
// Ports:
//   refclk     in   sole clock, everything on its rising edge
//   rst        in   synchronous active-high reset
//   cfg_wr     in   write strobe: shadow increment of cfg_ch <= cfg_inc
//   cfg_ch     in   target channel for cfg_wr (out-of-range writes ignored)
//   cfg_inc    in   new increment value
//   cfg_apply  in   copy all shadows to active, clear phases, restart settle
//   ce         out  per-channel single-cycle enable (accumulator carry)
//   outclk     out  per-channel square output (accumulator MSB)
//   locked     out  high once settled
// -----------------------------------------------------------------------------
module clkgen_ce_multi #(
  parameter int                          CHANNELS    = 3,
  parameter int                          ACC_W       = 32,
  parameter int                          LOCK_CYCLES = 16,
  parameter logic [CHANNELS*ACC_W-1:0]   INIT_INC    = '0,
  localparam int                         CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic                cfg_apply,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] outclk,
  output logic                locked
);

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Counter only needs to hold LOCK_CYCLES-1.
  localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_CYCLES - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_locked;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (cfg_apply) begin
      // An apply always restarts the settle window, even on the cycle the
      // counter would otherwise have expired.
      w_state_next = ST_SETTLE;
      w_cnt_next   = CNT_LOAD;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            w_state_next = ST_LOCKED;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
        ST_LOCKED: begin
          w_state_next = ST_LOCKED;
        end
        default: begin
          w_state_next = ST_SETTLE;
          w_cnt_next   = CNT_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state  <= ST_SETTLE;
      r_cnt    <= CNT_LOAD;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_locked <= (w_state_next == ST_LOCKED);
    end
  end

  assign locked = r_locked;

  // ---------------------------------------------------------------------------
  // Per-channel phase accumulators
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [ACC_W-1:0] r_acc;
      logic [ACC_W-1:0] r_inc;
      logic [ACC_W-1:0] r_sinc;
      logic             r_ce;
      logic             r_outclk;
      logic [ACC_W:0]   w_sum;
      logic             w_wr_hit;

      // Extra top bit of the sum is the wrap carry.
      assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

      // cfg_ch values at or above CHANNELS match no channel and are dropped.
      assign w_wr_hit = cfg_wr && (cfg_ch == CH_W'(gi));

      // Shadow register: writes are independent of apply, so a write in the
      // same cycle as an apply lands here only and waits for the next apply.
      always_ff @(posedge refclk) begin
        if (rst) begin
          r_sinc <= INIT_INC[gi*ACC_W +: ACC_W];
        end else if (w_wr_hit) begin
          r_sinc <= cfg_inc;
        end
      end

      // Active increment and accumulator. Apply reads r_sinc before the
      // same-edge write updates it.
      always_ff @(posedge refclk) begin
        if (rst) begin
          r_inc    <= INIT_INC[gi*ACC_W +: ACC_W];
          r_acc    <= '0;
          r_ce     <= 1'b0;
          r_outclk <= 1'b0;
        end else if (cfg_apply) begin
          r_inc    <= r_sinc;
          r_acc    <= '0;
          r_ce     <= 1'b0;
          r_outclk <= 1'b0;
        end else begin
          r_acc    <= w_sum[ACC_W-1:0];
          r_ce     <= w_sum[ACC_W];
          r_outclk <= w_sum[ACC_W-1];
        end
      end

      assign ce[gi]     = r_ce;
      assign outclk[gi] = r_outclk;
    end
  endgenerate

endmodule

// File: tb/tb_clkgen_ce_multi.sv
module tb_clkgen_ce_multi;

  localparam int          CHANNELS    = 3;
  localparam int          ACC_W       = 8;
  localparam int          LOCK_CYCLES = 4;
  // ch2 = 0 (stopped), ch1 = 3, ch0 = 64
  localparam logic [23:0] INIT_INC    = {8'd0, 8'd3, 8'd64};

  logic       refclk    = 1'b0;
  logic       rst       = 1'b1;
  logic       cfg_wr    = 1'b0;
  logic [1:0] cfg_ch    = 2'd0;
  logic [7:0] cfg_inc   = 8'd0;
  logic       cfg_apply = 1'b0;
  logic [2:0] ce;
  logic [2:0] outclk;
  logic       locked;

  int checks = 0;
  int errors = 0;
  int n_edge = 0;

  always #5 refclk = ~refclk;

  clkgen_ce_multi #(
    .CHANNELS   (CHANNELS),
    .ACC_W      (ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES),
    .INIT_INC   (INIT_INC)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .cfg_apply(cfg_apply),
    .ce       (ce),
    .outclk   (outclk),
    .locked   (locked)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running required finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (ce !== 3'b000) begin errors++; $display("FAIL reset_ce got %b exp 000", ce); end
    checks++;
    if (outclk !== 3'b000) begin errors++; $display("FAIL reset_outclk got %b exp 000", outclk); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    rst = 1'b0;
    n_edge = 0;
    $display("test_reset done");
  endtask

  // Edges 1..16 after reset release: ch0 period 4, ch1 idle so far, ch2 stopped.
  task automatic test_basic_rate();
    logic [2:0] exp_ce;
    logic [2:0] exp_oc;
    for (int n = 1; n <= 16; n++) begin
      tick();
      n_edge = n;
      exp_ce = {2'b00, (n % 4 == 0)};
      exp_oc = {2'b00, (n % 4 >= 2)};
      checks++;
      if (ce !== exp_ce) begin errors++; $display("FAIL basic_ce edge=%0d got %b exp %b", n, ce, exp_ce); end
      checks++;
      if (outclk !== exp_oc) begin errors++; $display("FAIL basic_outclk edge=%0d got %b exp %b", n, outclk, exp_oc); end
      checks++;
      if (locked !== (n >= 4)) begin errors++; $display("FAIL basic_locked edge=%0d got %b exp %b", n, locked, (n >= 4)); end
    end
    $display("test_basic_rate done");
  endtask

  // Edges 17..768: ch1 inc=3 gives 9 pulses at 86,171,256,...,768.
  task automatic test_fractional();
    int cnt1 = 0, first1 = 0, last1 = 0, min_sp = 100000, max_sp = 0;
    int cnt0 = 0, ch2_act = 0, unlock = 0;
    for (int n = 17; n <= 768; n++) begin
      tick();
      n_edge = n;
      if (ce[1]) begin
        if (cnt1 == 0) first1 = n;
        else begin
          if (n - last1 < min_sp) min_sp = n - last1;
          if (n - last1 > max_sp) max_sp = n - last1;
        end
        last1 = n;
        cnt1++;
      end
      if (ce[0]) cnt0++;
      if (ce[2] || outclk[2]) ch2_act++;
      if (!locked) unlock++;
    end
    checks++;
    if (cnt1 != 9) begin errors++; $display("FAIL frac_count got %0d exp 9", cnt1); end
    checks++;
    if (first1 != 86) begin errors++; $display("FAIL frac_first got %0d exp 86", first1); end
    checks++;
    if (min_sp != 85) begin errors++; $display("FAIL frac_min_spacing got %0d exp 85", min_sp); end
    checks++;
    if (max_sp != 86) begin errors++; $display("FAIL frac_max_spacing got %0d exp 86", max_sp); end
    checks++;
    if (last1 != 768) begin errors++; $display("FAIL frac_last got %0d exp 768", last1); end
    checks++;
    if (cnt0 != 188) begin errors++; $display("FAIL ch0_count got %0d exp 188", cnt0); end
    checks++;
    if (ch2_act != 0) begin errors++; $display("FAIL ch2_stopped got %0d active cycles exp 0", ch2_act); end
    checks++;
    if (unlock != 0) begin errors++; $display("FAIL lock_held got %0d unlocked cycles exp 0", unlock); end
    $display("test_fractional done ch1_pulses=%0d", cnt1);
  endtask

  // Shadow write without apply, then apply and realignment.
  task automatic test_shadow_apply();
    int ch2_act = 0;
    logic [2:0] exp_ce;
    logic [2:0] exp_oc;
    cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_inc = 8'd128;
    tick();
    cfg_wr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (ce[2] || outclk[2]) ch2_act++;
    end
    checks++;
    if (ch2_act != 0) begin errors++; $display("FAIL shadow_no_effect got %0d active cycles exp 0", ch2_act); end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL pre_apply_locked got %b exp 1", locked); end
    cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL apply_locked_fall got %b exp 0", locked); end
    checks++;
    if ({ce, outclk} !== 6'b0) begin errors++; $display("FAIL apply_clear got ce=%b oc=%b exp 000 000", ce, outclk); end
    for (int m = 1; m <= 8; m++) begin
      tick();
      exp_ce = {(m % 2 == 0), 1'b0, (m % 4 == 0)};
      exp_oc = {(m % 2 == 1), 1'b0, (m % 4 >= 2)};
      checks++;
      if (ce !== exp_ce) begin errors++; $display("FAIL realign_ce m=%0d got %b exp %b", m, ce, exp_ce); end
      checks++;
      if (outclk !== exp_oc) begin errors++; $display("FAIL realign_outclk m=%0d got %b exp %b", m, outclk, exp_oc); end
      checks++;
      if (locked !== (m >= 4)) begin errors++; $display("FAIL realign_locked m=%0d got %b exp %b", m, locked, (m >= 4)); end
    end
    $display("test_shadow_apply done");
  endtask

  // Out-of-range write, write+apply in same cycle, then inc=32 and inc=255.
  task automatic test_cfg_corner();
    int cnt1 = 0;
    logic [2:0] exp_ce;
    logic [2:0] exp_oc;
    cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_inc = 8'd5;
    tick();
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd32; cfg_apply = 1'b1;
    tick();
    cfg_wr = 1'b0; cfg_apply = 1'b0;
    // Active: ch0 64, ch1 3, ch2 128
    for (int m = 1; m <= 88; m++) begin
      tick();
      exp_ce = {(m % 2 == 0), (m == 86), (m % 4 == 0)};
      exp_oc = {(m % 2 == 1), (m >= 43 && m <= 85), (m % 4 >= 2)};
      checks++;
      if (ce !== exp_ce) begin errors++; $display("FAIL same_cycle_ce m=%0d got %b exp %b", m, ce, exp_ce); end
      checks++;
      if (outclk !== exp_oc) begin errors++; $display("FAIL same_cycle_outclk m=%0d got %b exp %b", m, outclk, exp_oc); end
    end
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_inc = 8'd255;
    tick();
    cfg_wr = 1'b0; cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
    // Active: ch0 32, ch1 255, ch2 128
    for (int m = 1; m <= 512; m++) begin
      tick();
      exp_ce = {(m % 2 == 0), (m % 256 != 1), (m % 8 == 0)};
      exp_oc = {(m % 2 == 1), (m % 256 >= 1 && m % 256 <= 128), (m % 8 >= 4)};
      if (ce[1]) cnt1++;
      checks++;
      if (ce !== exp_ce) begin errors++; $display("FAIL second_apply_ce m=%0d got %b exp %b", m, ce, exp_ce); end
      checks++;
      if (outclk !== exp_oc) begin errors++; $display("FAIL second_apply_outclk m=%0d got %b exp %b", m, outclk, exp_oc); end
    end
    checks++;
    if (cnt1 != 510) begin errors++; $display("FAIL inc255_count got %0d exp 510", cnt1); end
    $display("test_cfg_corner done inc255_pulses=%0d", cnt1);
  endtask

  task automatic test_apply_storm();
    for (int k = 0; k < 10; k++) begin
      cfg_apply = 1'b1;
      tick();
      cfg_apply = 1'b0;
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL storm_locked k=%0d j=%0d got %b exp 0", k, j, locked); end
        if (j < 2) tick();
      end
    end
    // Apply at A, then again at A+4 when the counter sits at zero.
    cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
    repeat (3) tick();
    cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL apply_at_zero got %b exp 0", locked); end
    for (int j = 1; j <= 4; j++) begin
      tick();
      checks++;
      if (locked !== (j == 4)) begin errors++; $display("FAIL relock j=%0d got %b exp %b", j, locked, (j == 4)); end
    end
    $display("test_apply_storm done");
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp_ce;
    logic [2:0] exp_oc;
    // Mid-SETTLE reset after shadow writes and an apply.
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd16;
    tick();
    cfg_ch = 2'd2; cfg_inc = 8'd8;
    tick();
    cfg_wr = 1'b0; cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ce, outclk, locked} !== 7'b0) begin errors++; $display("FAIL rst_settle_clear got ce=%b oc=%b lk=%b exp all 0", ce, outclk, locked); end
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_ce = {2'b00, (n % 4 == 0)};
      exp_oc = {2'b00, (n % 4 >= 2)};
      checks++;
      if ({ce, outclk, locked} !== {exp_ce, exp_oc, (n >= 4)}) begin
        errors++;
        $display("FAIL rst_settle_seq edge=%0d got ce=%b oc=%b lk=%b exp ce=%b oc=%b lk=%b", n, ce, outclk, locked, exp_ce, exp_oc, (n >= 4));
      end
    end
    // Mid-LOCKED reset after shadow writes; a later apply must use INIT_INC.
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd16;
    tick();
    cfg_ch = 2'd2; cfg_inc = 8'd8;
    tick();
    cfg_wr = 1'b0;
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL pre_rst_locked got %b exp 1", locked); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ce, outclk, locked} !== 7'b0) begin errors++; $display("FAIL rst_locked_clear got ce=%b oc=%b lk=%b exp all 0", ce, outclk, locked); end
    repeat (2) tick();
    cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      tick();
      exp_ce = {2'b00, (m % 4 == 0)};
      exp_oc = {2'b00, (m % 4 >= 2)};
      checks++;
      if ({ce, outclk, locked} !== {exp_ce, exp_oc, (m >= 4)}) begin
        errors++;
        $display("FAIL shadow_discard m=%0d got ce=%b oc=%b lk=%b exp ce=%b oc=%b lk=%b", m, ce, outclk, locked, exp_ce, exp_oc, (m >= 4));
      end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic_rate();
    test_fractional();
    test_shadow_apply();
    test_cfg_corner();
    test_apply_storm();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clkgen_ce_multi.md
# clkgen_ce_multi

Multi-channel, runtime-programmable fractional clock-enable generator. It runs on a single fabric clock from the PLL and derives CHANNELS independent clock-enable strobes plus 50%-duty square outputs using phase accumulators. This replaces fixed extra PLL outputs with numerically controlled rates. Rates are reprogrammable without reconfiguring the PLL. A PLL-style `locked` flag reports when all channels have settled after reset or reconfiguration.

## Interface
- CHANNELS, 3, number of output channels (1..16)
- ACC_W, 32, accumulator / increment width in bits (4..48)
- LOCK_CYCLES, 16, settle time in clocks before `locked` asserts (≥1)
- INIT_INC, 0, packed CHANNELS*ACC_W reset increments; channel i in bits [i*ACC_W +: ACC_W]
- CH_W, derived: max(1, $clog2(CHANNELS))

Ports:
- refclk  in  1  sole clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- cfg_wr  in  1  write strobe: load shadow increment of channel cfg_ch
- cfg_ch  in  CH_W  target channel for cfg_wr
- cfg_inc  in  ACC_W  new increment value
- cfg_apply  in  1  copy all shadow increments to active, realign phases
- ce  out  CHANNELS  single-cycle enable per channel
- outclk  out  CHANNELS  square output per channel (accumulator MSB)
- locked  out  1  high when settled

## Operation
- Per channel i: registered acc[i] (ACC_W), active inc[i], shadow sinc[i].
- Each cycle: {carry, sum} = acc + inc in ACC_W+1 bits; acc <= sum (wraps mod 2^ACC_W); ce[i] <= carry; outclk[i] <= sum[ACC_W-1].
- Output rate = f_refclk * inc / 2^ACC_W. inc=0 stops the channel: ce=0, outclk frozen at the MSB of acc, which is 0 after apply or reset. inc=2^ACC_W-1 gives ce high on all but one cycle in 2^ACC_W.
- cfg_wr: sinc[cfg_ch] <= cfg_inc. A write with cfg_ch ≥ CHANNELS is ignored. Active rates are unchanged until apply.
- cfg_apply: all inc <= sinc simultaneously; all acc <= 0; ce <= 0; outclk <= 0. Phase-aligns every channel.
- cfg_wr and cfg_apply in the same cycle: apply uses the shadow values as they were before this cycle. The write lands in the shadow only and takes effect at the next apply.
- Lock FSM, states:
  - SETTLE: counter cnt counts down; locked=0.
  - LOCKED: locked=1.
- Transitions:
  - rst → SETTLE with cnt=LOCK_CYCLES-1.
  - SETTLE with cnt=0 → LOCKED; otherwise cnt--.
  - cfg_apply in any state → SETTLE with cnt=LOCK_CYCLES-1. Apply takes priority over the count reaching zero.
- Accumulators run during SETTLE. Outputs are valid but flagged unsettled.
- Reset values: acc=0, inc=sinc=INIT_INC, ce=0, outclk=0, locked=0, state SETTLE.

## Timing
- All outputs are registered.
- After rst deasserts or after the apply edge, acc after the n-th subsequent edge = n*inc mod 2^ACC_W.
- ce is high in the cycle following edge n whenever n*inc crosses a multiple of 2^ACC_W.
- First ce pulse: after edge ceil(2^ACC_W / inc).
- Pulse spacing: floor or ceil of 2^ACC_W / inc. Exactly inc pulses occur per 2^ACC_W cycles, with no drift.
- locked rises on the LOCK_CYCLES-th edge after rst is sampled low or cfg_apply is sampled high.
- locked falls on the edge that samples cfg_apply (1-cycle latency).
- rst mid-SETTLE or mid-operation restores all reset values on the next edge. Shadow writes are discarded.
- cfg_wr during SETTLE is accepted normally.

## Test plan
1. ACC_W=8, CHANNELS=3, LOCK_CYCLES=4, INIT_INC ch0=64; release rst → ce[0] high after edges 4, 8, 12…; outclk[0] high after edges 2–3, low after edges 4–5 (50% duty, period 4); locked high after edge 4.
2. Same configuration, ch1 inc=3; run 768 cycles → exactly 9 ce[1] pulses, first after edge 86, spacing 85/86. inc=255 → ce high 255 of every 256 cycles. inc=0 → ce and outclk stay 0.
3. cfg_wr ch2 inc=128 with no apply → ch2 unchanged for 100 cycles. Then cfg_apply → locked=0 the next cycle; all acc=0; ce[2] high after edges 2, 4, 6…; ce[0] realigned to edges 4, 8…; locked returns after edge 4.
4. cfg_wr with cfg_ch=3 (out of range) → no shadow or active change. cfg_wr ch0 inc=32 and cfg_apply in the same cycle → ch0 keeps its old shadow value; a second apply later → ch0 period becomes 8.
5. cfg_apply every 3 cycles → locked never asserts. cfg_apply in the same cycle the counter reaches 0 → stays SETTLE.
6. rst pulsed mid-SETTLE and mid-LOCKED after shadow writes → all outputs 0 next cycle; increments revert to INIT_INC; lock sequence restarts with locked high after edge 4.
